if_stage: RTL

Instruction fetch stage: holds the PC, fetches one 32-bit instruction at a time over a single-outstanding request/acknowledge port to instruction memory, and presents it to the decoder through an IF/ID register. It sits directly upstream of `i_decoder`. It accepts stall requests from the hazard unit and redirect requests from branch/jump resolution in EX. A one-entry skid buffer keeps the memory handshake legal when a stall arrives mid-request.

---
 rtl/if_stage_if.sv | 28 ++
 rtl/if_stage.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory fetch port.
//   imem_req   : fetch request, held until imem_ack.
//   imem_addr  : fetch address, stable while imem_req is high, word aligned.
//   imem_ack   : completion strobe, meaningful only while imem_req is high.
//   imem_rdata : instruction word, valid in the imem_ack cycle.
// Modports: master = fetch unit, slave = instruction memory.
interface if_stage_if #(
    parameter int WORD_SIZE = 32
);
    logic                 imem_req;
    logic [WORD_SIZE-1:0] imem_addr;
    logic                 imem_ack;
    logic [WORD_SIZE-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage.
// Holds the PC, fetches one instruction at a time over a single-outstanding
// req/ack port and presents it to the decoder through the IF/ID register.
// A one-entry skid buffer absorbs a response that arrives while the decoder
// is stalled, so the memory handshake never has to be aborted.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset.
//   imem            : fetch port (if_stage_if.master).
//   id_stall        : hold the IF/ID register.
//   redirect_valid  : taken branch/jump; flush and refetch from redirect_pc.
//   redirect_pc     : redirect target, low two bits ignored.
//   id_valid        : IF/ID holds a live instruction.
//   id_instr        : instruction to the decoder (NOP_INSTR when invalid).
//   id_pc           : address of id_instr.
//   id_pc_plus4     : id_pc + 4, wrapping.
module if_stage #(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    if_stage_if.master           imem,
    input  logic                 id_stall,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 id_valid,
    output logic [WORD_SIZE-1:0] id_instr,
    output logic [WORD_SIZE-1:0] id_pc,
    output logic [WORD_SIZE-1:0] id_pc_plus4
);
    localparam logic [WORD_SIZE-1:0] FOUR = WORD_SIZE'(4);

    // DROP: a redirect arrived while a request was outstanding; the request
    // must stay up until its (now stale) ack returns.
    typedef enum logic [1:0] {BOOT, REQ, IDLE, DROP} state_t;

    state_t               state_reg;
    logic [WORD_SIZE-1:0] pc_reg;
    logic [WORD_SIZE-1:0] addr_reg;
    logic                 skid_valid_reg;
    logic [WORD_SIZE-1:0] skid_instr_reg;
    logic [WORD_SIZE-1:0] skid_pc_reg;

    logic [WORD_SIZE-1:0] redirect_target;
    logic [WORD_SIZE-1:0] pc_plus4;
    logic                 fetch_done;
    logic                 id_open;
    logic                 unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[WORD_SIZE-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign pc_plus4             = pc_reg + FOUR;
    // Only an ack in REQ carries useful data; acks in DROP are stale.
    assign fetch_done           = (state_reg == REQ) && imem.imem_ack;
    // IF/ID can accept a new instruction this cycle.
    assign id_open              = !id_valid || !id_stall;

    assign imem.imem_req  = (state_reg == REQ) || (state_reg == DROP);
    assign imem.imem_addr = addr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= BOOT;
            pc_reg         <= RESET_PC;
            addr_reg       <= RESET_PC;
            skid_valid_reg <= 1'b0;
            skid_instr_reg <= NOP_INSTR;
            skid_pc_reg    <= '0;
            id_valid       <= 1'b0;
            id_instr       <= NOP_INSTR;
            id_pc          <= '0;
            id_pc_plus4    <= FOUR;
        end else begin
            // ---------------- fetch FSM ----------------
            case (state_reg)
                BOOT: begin
                    state_reg <= REQ;
                    pc_reg    <= RESET_PC;
                    addr_reg  <= RESET_PC;
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc_reg <= redirect_target;
                        if (imem.imem_ack) begin
                            addr_reg <= redirect_target;
                        end else begin
                            state_reg <= DROP;
                        end
                    end else if (imem.imem_ack) begin
                        // pc equals addr_reg in REQ, so pc + 4 is the next word.
                        pc_reg <= pc_plus4;
                        if (id_open) begin
                            addr_reg <= pc_plus4;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (redirect_valid) begin
                        pc_reg    <= redirect_target;
                        addr_reg  <= redirect_target;
                        state_reg <= REQ;
                    end else if (!id_stall) begin
                        addr_reg  <= pc_reg;
                        state_reg <= REQ;
                    end
                end
                DROP: begin
                    if (redirect_valid) begin
                        pc_reg <= redirect_target;
                    end
                    if (imem.imem_ack) begin
                        addr_reg  <= redirect_valid ? redirect_target : pc_reg;
                        state_reg <= REQ;
                    end
                end
                default: state_reg <= BOOT;
            endcase

            // ---------------- IF/ID and skid ----------------
            // Redirect has priority over stall: wrong-path work is dropped.
            if (redirect_valid) begin
                id_valid       <= 1'b0;
                id_instr       <= NOP_INSTR;
                skid_valid_reg <= 1'b0;
            end else if (id_open) begin
                if (skid_valid_reg) begin
                    id_valid       <= 1'b1;
                    id_instr       <= skid_instr_reg;
                    id_pc          <= skid_pc_reg;
                    id_pc_plus4    <= skid_pc_reg + FOUR;
                    skid_valid_reg <= 1'b0;
                end else if (fetch_done) begin
                    id_valid    <= 1'b1;
                    id_instr    <= imem.imem_rdata;
                    id_pc       <= addr_reg;
                    id_pc_plus4 <= addr_reg + FOUR;
                end else begin
                    id_valid <= 1'b0;
                    id_instr <= NOP_INSTR;
                end
            end else if (fetch_done) begin
                // Decoder is holding a live instruction: park the response.
                skid_valid_reg <= 1'b1;
                skid_instr_reg <= imem.imem_rdata;
                skid_pc_reg    <= addr_reg;
            end
        end
    end
endmodule
